// File: rtl/display_pkg.sv
// Shared constants and state encoding for the segment-display BCD feeder.
package display_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE = 2'd0;
   localparam state_t CONV = 2'd1;
   localparam state_t DONE = 2'd2;

   // Largest operand that fits in eight decimal digits.
   localparam logic [31:0] BCD_MAX = 32'd99_999_999;
   // Shown on the display when the operand does not fit.
   localparam logic [31:0] BCD_ERR = 32'hEEEE_EEEE;
   // One shift per binary input bit.
   localparam int unsigned CONV_ITERS = 32;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: add 3 to a BCD nibble that is 5 or more.
module bcd_add3 (
   input  logic [3:0] din,
   output logic [3:0] dout
);

   // Pre-shift correction so the doubled digit carries into the next nibble.
   always_comb begin
      dout = din;
      if (din >= 4'd5) begin
         dout = din + 4'd3;
      end
   end

endmodule

// File: rtl/bcd_display_feeder.sv
// Binary-to-packed-BCD feeder for the eight-digit segment display.
// Iterative shift-and-add-3 converter with a one-deep pending-write buffer.
// Optional macro HEX_PASSTHRU_EN adds a hex_mode input that bypasses conversion.
module bcd_display_feeder
   import display_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic [31:0] wr_data,
`ifdef HEX_PASSTHRU_EN
   input  logic        hex_mode,
`endif
   output logic [31:0] value,
   output logic        io_out_en,
   output logic        busy,
   output logic        overflow
);

   state_t      state;
   logic [4:0]  cnt;
   logic [63:0] shreg;      // {bcd, bin}; upper half also holds the result for DONE
   logic        res_ovf;
   logic [31:0] pend_data;
   logic        pend_valid;

   logic        launch;
   logic [31:0] src_data;
   logic        src_hex;
   logic [31:0] adj;
   logic [63:0] shifted;

`ifdef HEX_PASSTHRU_EN
   logic pend_hex;

   assign src_hex = wr_en ? hex_mode : pend_hex;

   // Hex flag travels with the pending operand.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_hex <= 1'b0;
      end else if (wr_en && (state != IDLE)) begin
         pend_hex <= hex_mode;
      end
   end
`else
   assign src_hex = 1'b0;
`endif

   // A fresh store takes priority over the buffered one.
   assign launch   = (state == IDLE) && (wr_en || pend_valid);
   assign src_data = wr_en ? wr_data : pend_data;

   genvar g;
   for (g = 0; g < 8; g++) begin : g_digit
      bcd_add3 u_add3 (
         .din  (shreg[32 + 4*g +: 4]),
         .dout (adj[4*g +: 4])
      );
   end

   assign shifted = {adj, shreg[31:0]};
   assign busy    = (state != IDLE);

   // Conversion sequencer, result registers and pending buffer.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= 5'd0;
         shreg      <= 64'd0;
         res_ovf    <= 1'b0;
         pend_data  <= 32'd0;
         pend_valid <= 1'b0;
         value      <= 32'd0;
         io_out_en  <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (launch) begin
                  pend_valid <= 1'b0;
                  if (src_hex) begin
                     shreg   <= {src_data, 32'd0};
                     res_ovf <= 1'b0;
                     state   <= DONE;
                  end else if (src_data > BCD_MAX) begin
                     shreg   <= {BCD_ERR, 32'd0};
                     res_ovf <= 1'b1;
                     state   <= DONE;
                  end else begin
                     shreg   <= {32'd0, src_data};
                     res_ovf <= 1'b0;
                     cnt     <= 5'd0;
                     state   <= CONV;
                  end
               end
            end
            CONV: begin
               shreg <= shifted << 1;
               cnt   <= cnt + 5'd1;
               if (cnt == 5'(CONV_ITERS - 1)) begin
                  state <= DONE;
               end
            end
            DONE: begin
               value     <= shreg[63:32];
               overflow  <= res_ovf;
               io_out_en <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase

         // Stores arriving while busy are buffered; the latest one wins.
         if (wr_en && (state != IDLE)) begin
            pend_data  <= wr_data;
            pend_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_bcd_display_feeder.sv
// Self-checking bench for bcd_display_feeder: vector table plus corner sequences.
module tb_bcd_display_feeder;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en;
   logic [31:0] wr_data;
   logic [31:0] value;
   logic        io_out_en;
   logic        busy;
   logic        overflow;
`ifdef HEX_PASSTHRU_EN
   logic        hex_mode;
`endif

   bcd_display_feeder dut (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
`ifdef HEX_PASSTHRU_EN
      .hex_mode  (hex_mode),
`endif
      .value     (value),
      .io_out_en (io_out_en),
      .busy      (busy),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] operand;
      logic [31:0] exp_value;
      logic        exp_ovf;
      int          exp_lat;   // edges after the strobe edge until busy drops
   } vec_t;

   vec_t vecs[8];
   int   errors = 0;
   int   checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Strobe one store; returns just after its sampling edge.
   task automatic write(input logic [31:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      step();
      wr_en   = 1'b0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 100) begin
         step();
         n++;
      end
   endtask

   int n;

   initial begin
      rst     = 1'b1;
      wr_en   = 1'b0;
      wr_data = 32'd0;
`ifdef HEX_PASSTHRU_EN
      hex_mode = 1'b0;
`endif
      vecs[0] = '{32'd12_345_678,  32'h1234_5678, 1'b0, 33};
      vecs[1] = '{32'd99_999_999,  32'h9999_9999, 1'b0, 33};
      vecs[2] = '{32'd100_000_000, 32'hEEEE_EEEE, 1'b1, 1};
      vecs[3] = '{32'd7,           32'h0000_0007, 1'b0, 33};
      vecs[4] = '{32'd0,           32'h0000_0000, 1'b0, 33};
      vecs[5] = '{32'hFFFF_FFFF,   32'hEEEE_EEEE, 1'b1, 1};
      vecs[6] = '{32'd10,          32'h0000_0010, 1'b0, 33};
      vecs[7] = '{32'd90_817_263,  32'h9081_7263, 1'b0, 33};

      repeat (3) step();
      rst = 1'b0;
      repeat (10) step();
      check("reset_value", value, 32'd0);
      check("reset_io_out_en", {31'd0, io_out_en}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_overflow", {31'd0, overflow}, 32'd0);

      for (int i = 0; i < 8; i++) begin
         write(vecs[i].operand);
         check($sformatf("v%0d_busy_after_strobe", i), {31'd0, busy}, 32'd1);
         wait_idle(n);
         check($sformatf("v%0d_latency", i), n, vecs[i].exp_lat);
         check($sformatf("v%0d_value", i), value, vecs[i].exp_value);
         check($sformatf("v%0d_overflow", i), {31'd0, overflow}, {31'd0, vecs[i].exp_ovf});
         check($sformatf("v%0d_io_out_en", i), {31'd0, io_out_en}, 32'd1);
         step();
      end

      // Writes during a conversion: 3 overwrites 2 in the pending buffer.
      write(32'd1);
      repeat (4) step();
      write(32'd2);
      check("hold_prev_value", value, 32'h9081_7263);
      repeat (4) step();
      write(32'd3);
      wait_idle(n);
      check("pend_first_lat", n, 23);
      check("pend_first_value", value, 32'h0000_0001);
      step();
      check("pend_launch_busy", {31'd0, busy}, 32'd1);
      wait_idle(n);
      check("pend_second_lat", n, 33);
      check("pend_second_value", value, 32'h0000_0003);
      step();

      // Write on the DONE edge lands in pending and launches on the next edge.
      write(32'd4);
      repeat (32) step();
      check("done_edge_busy", {31'd0, busy}, 32'd1);
      write(32'd5);
      check("done_edge_value", value, 32'h0000_0004);
      check("done_edge_idle", {31'd0, busy}, 32'd0);
      step();
      check("done_edge_launch", {31'd0, busy}, 32'd1);
      wait_idle(n);
      check("done_edge_second", value, 32'h0000_0005);
      step();

      // Reset mid-conversion with a store pending.
      write(32'd55_555_555);
      repeat (4) step();
      write(32'd9);
      repeat (10) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_value", value, 32'd0);
      check("rst_io_out_en", {31'd0, io_out_en}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_overflow", {31'd0, overflow}, 32'd0);
      repeat (80) step();
      check("rst_no_done_value", value, 32'd0);
      check("rst_no_done_io_out_en", {31'd0, io_out_en}, 32'd0);
      check("rst_pending_empty_busy", {31'd0, busy}, 32'd0);

`ifdef HEX_PASSTHRU_EN
      hex_mode = 1'b1;
      write(32'hDEAD_BEEF);
      hex_mode = 1'b0;
      step();
      check("hex_value", value, 32'hDEAD_BEEF);
      check("hex_overflow", {31'd0, overflow}, 32'd0);
      check("hex_busy", {31'd0, busy}, 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
